// File: rtl/prog_loader.sv
// Boot/run sequencer: streams machine-code words into the instruction ROM,
// releases the core from reset, then counts its cycles until done or timeout.
module prog_loader #(
   parameter int unsigned D  = 12,
   parameter int unsigned W  = 9,
   parameter int unsigned CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          inValid,
   output logic          inReady,
   input  logic [W-1:0]  inData,
   input  logic          inLast,
   output logic          romWrEn,
   output logic [D-1:0]  romWrAddr,
   output logic [W-1:0]  romWrData,
   output logic          cpuReset,
   input  logic          cpuDone,
   output logic          busy,
   output logic          finished,
   output logic          error,
   output logic [D:0]    wordCount,
   output logic [CW-1:0] cycleCount
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRelease,
      StRun,
      StDone,
      StError
   } state_t;

   localparam logic [D:0]    WordOne  = {{D{1'b0}}, 1'b1};
   localparam logic [D-1:0]  PtrOne   = {{(D-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CycOne   = {{(CW-1){1'b0}}, 1'b1};
   // One below saturation: reaching all-ones on this edge means timeout.
   localparam logic [CW-1:0] CycLast  = {{(CW-1){1'b1}}, 1'b0};

   state_t        r_state;
   logic [D-1:0]  r_ptr;
   logic          r_wr_en;
   logic [D-1:0]  r_wr_addr;
   logic [W-1:0]  r_wr_data;
   logic          r_cpu_reset;
   logic [D:0]    r_words;
   logic [CW-1:0] r_cycles;

   logic          w_hs;
   logic          w_ptr_max;

   assign w_hs      = inValid && (r_state == StLoad);
   assign w_ptr_max = &r_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_ptr       <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_cpu_reset <= 1'b1;
         r_words     <= '0;
         r_cycles    <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            StIdle, StDone, StError: begin
               if (start) begin
                  r_state  <= StLoad;
                  r_ptr    <= '0;
                  r_words  <= '0;
                  r_cycles <= '0;
               end
            end
            StLoad: begin
               if (w_hs) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_ptr;
                  r_wr_data <= inData;
                  r_words   <= r_words + WordOne;
                  // Pointer sticks at the top address instead of wrapping.
                  if (!w_ptr_max) r_ptr <= r_ptr + PtrOne;
                  if (inLast)         r_state <= StRelease;
                  else if (w_ptr_max) r_state <= StError;
               end
            end
            StRelease: begin
               r_state     <= StRun;
               r_cpu_reset <= 1'b0;
            end
            StRun: begin
               r_cycles <= r_cycles + CycOne;
               if (cpuDone) begin
                  r_state     <= StDone;
                  r_cpu_reset <= 1'b1;
               end else if (r_cycles == CycLast) begin
                  r_state     <= StError;
                  r_cpu_reset <= 1'b1;
               end
            end
            default: begin
               r_state     <= StIdle;
               r_cpu_reset <= 1'b1;
            end
         endcase
      end
   end

   assign inReady    = (r_state == StLoad);
   assign busy       = (r_state == StLoad) || (r_state == StRelease) || (r_state == StRun);
   assign finished   = (r_state == StDone);
   assign error      = (r_state == StError);
   assign romWrEn    = r_wr_en;
   assign romWrAddr  = r_wr_addr;
   assign romWrData  = r_wr_data;
   assign cpuReset   = r_cpu_reset;
   assign wordCount  = r_words;
   assign cycleCount = r_cycles;

endmodule
